paint_scan_streamer: RTL and testbench
======================================

// Module: paint_scan_streamer
// PURPOSE
//  Drives paint_x/paint_y into the fixed-latency layer paint pipelines (background, sprites),
//  re-times the returned paint_color and buffers it as a ready/valid RGB565 pixel stream for
//  the LCD write interface. Credit flow control stops coordinate issue before the buffer can
//  overflow, because the paint pipelines cannot stall. One instance sits between frame control
//  and the LCD writer.
// PARAMETERS
//  X_SIZE      800  pixels per line; paint_x runs 0..X_SIZE-1, fastest-changing
//  Y_SIZE      480  lines per frame; paint_y runs 0..Y_SIZE-1
//  LATENCY     5    cycles from paint_x/paint_y output to matching paint_color input
//  FIFO_DEPTH  16   output buffer entries, power of two, >= LATENCY+1
// PORTS
//  clk          in   1   clock
//  rstn         in   1   synchronous active-low reset
//  frame_start  in   1   one-cycle request to scan one frame; honoured only in IDLE
//  busy         out  1   high in SCAN and DRAIN
//  frame_done   out  1   one-cycle pulse when the last pixel of a frame is accepted
//  paint_x      out  16  signed x coordinate to the paint pipelines
//  paint_y      out  16  signed y coordinate to the paint pipelines
//  paint_color  in   16  RGB565 from the pipelines, LATENCY cycles after the coordinate
//  pix_data     out  16  RGB565 pixel to the LCD writer
//  pix_valid    out  1   pix_data valid
//  pix_ready    in   1   LCD writer accepts; transfer = pix_valid & pix_ready
//  pix_sof      out  1   qualifies pix_data: first pixel of frame (x=0,y=0)
//  pix_eol      out  1   qualifies pix_data: last pixel of line (x=X_SIZE-1)
// BEHAVIOUR
//  Reset: state IDLE; paint_x=paint_y=0; FIFO and in-flight tags cleared; busy, frame_done,
//   pix_valid, pix_sof and pix_eol = 0; pix_data = 0. Reset mid-frame discards all in-flight
//   and buffered pixels; the next frame restarts at (0,0).
//  FSM: IDLE -frame_start-> SCAN (x,y=0). SCAN -last coordinate issued-> DRAIN.
//   DRAIN -in-flight=0 & FIFO empty-> IDLE, with the frame_done pulse on the cycle the
//   last pixel transfers. frame_start in SCAN or DRAIN is ignored, not queued.
//  Issue: issue = SCAN & (fifo_count + inflight < FIFO_DEPTH). paint_x/paint_y are registered.
//   On an issue cycle they carry the new coordinate. Otherwise they hold their value and the
//   pipeline result is discarded. Order: x increments. At x=X_SIZE-1, x wraps to 0 and y
//   increments. At (X_SIZE-1, Y_SIZE-1), SCAN ends.
//  Tag line: LATENCY-stage shift register {valid,sof,eol} aligned with the coordinate register.
//   A coordinate presented at cycle t has its paint_color captured into the FIFO at t+LATENCY,
//   when the tag valid bit is set. It is earliest visible on pix_valid at t+LATENCY+1.
//  inflight: count of set tag valid bits, width clog2(LATENCY+1). It updates on issue and on
//   tag retire in the same cycle without loss.
//  FIFO: show-ahead; width 18 {sof,eol,color}. pix_valid = !empty. A simultaneous write and read
//   is legal at any occupancy, including full. A write when full is impossible by credit;
//   assert it.
//  Throughput: 1 pixel/cycle with pix_ready held 1. With pix_ready=0, issue stops when
//   fifo_count+inflight reaches FIFO_DEPTH. It resumes the cycle after a transfer frees a slot.
//  pix_data/sof/eol hold steady while pix_valid & !pix_ready.
//  Coordinate arithmetic: unsigned counters zero-extended into the signed 16-bit outputs.
//   X_SIZE,Y_SIZE <= 32767.
// STRUCTURE
//  Shared include (lcd_defs.vh): LCD_X_SIZE=800, LCD_Y_SIZE=480, PAINT_LATENCY=5,
//   RGB565 width, and the FSM state encodings IDLE/SCAN/DRAIN.
//  Sub-module pix_fifo (WIDTH, DEPTH; sync, show-ahead, count output). Scan FSM, coordinate
//   counters, tag shift register and credit logic live in this module.
// TESTING  (stub pipeline: paint_color = {x[7:0],y[7:0]} delayed LATENCY cycles)
//  1. X_SIZE=4,Y_SIZE=3, pix_ready=1, frame_start pulse: exactly 12 pixels in raster order.
//     sof only on (0,0); eol on x=3 (3 times); frame_done once, with the 12th transfer.
//  2. pix_ready=0 after frame_start: exactly FIFO_DEPTH coordinates are issued and then
//     paint_x freezes. Raise ready: all pixels arrive, none lost or duplicated.
//  3. Random pix_ready (50%) over a full 800x480 frame: scoreboard matches all 384000 pixels.
//     No FIFO overflow assertion fires.
//  4. frame_start pulsed during SCAN and during DRAIN: ignored; busy stays high; one frame_done.
//     A second frame_start after done scans a fresh frame from (0,0).
//  5. rstn low for 1 cycle mid-frame (e.g. y=100): all outputs return to reset values next
//     cycle. A following frame_start yields a clean frame with sof on its first pixel.
//  6. pix_ready=1 throughput: frame_start to frame_done = X_SIZE*Y_SIZE+LATENCY+1 cycles
//     (±1 if the FSM adds a start cycle); no gaps in pix_valid after the first pixel.

Source files
------------

// File: rtl/paint_scan_streamer_pkg.sv
// Shared definitions for the paint scan streamer: LCD geometry, paint latency,
// the RGB565 width, scan FSM states and the tag/FIFO payload layouts.
package paint_scan_streamer_pkg;

    localparam int unsigned LCD_X_SIZE     = 800;
    localparam int unsigned LCD_Y_SIZE     = 480;
    localparam int unsigned PAINT_LATENCY  = 5;
    localparam int unsigned PIX_FIFO_DEPTH = 16;
    localparam int unsigned RGB565_W       = 16;
    localparam int unsigned COORD_W        = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic valid;
        logic sof;
        logic eol;
    } pix_tag_t;

    typedef struct packed {
        logic                sof;
        logic                eol;
        logic [RGB565_W-1:0] color;
    } pix_entry_t;

endpackage

// File: rtl/paint_scan_streamer_pix_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; read data is zero while empty.
module paint_scan_streamer_pix_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     rd_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             wr_en;
    logic             rd_en;

    always_comb begin
        empty_o = (count_q == '0);
        full    = (count_q == CW'(DEPTH));
        rd_en   = rd_i && !empty_o;
        // A write into a full FIFO is accepted only alongside a read.
        wr_en   = wr_i && (!full || rd_en);
        rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
        count_o = count_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rstn) !(wr_i && full && !rd_i))
        else $error("pix_fifo write while full without read");

endmodule

// File: rtl/paint_scan_streamer.sv
// Issues raster coordinates to the fixed-latency paint pipelines under credit control
// and streams the returned colours as a ready/valid RGB565 pixel stream.
module paint_scan_streamer
    import paint_scan_streamer_pkg::*;
#(
    parameter int unsigned X_SIZE     = LCD_X_SIZE,
    parameter int unsigned Y_SIZE     = LCD_Y_SIZE,
    parameter int unsigned LATENCY    = PAINT_LATENCY,
    parameter int unsigned FIFO_DEPTH = PIX_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        frame_start,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] paint_x,
    output logic [15:0] paint_y,
    input  logic [15:0] paint_color,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol
);

    localparam int unsigned CW    = COORD_W - 1;
    localparam int unsigned TAG_N = LATENCY + 1;
    localparam int unsigned IF_W  = $clog2(LATENCY + 2);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [CW-1:0] X_LAST = CW'(X_SIZE - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(Y_SIZE - 1);

    scan_state_e       state_q;
    logic              busy_q;
    logic [CW-1:0]     x_q;
    logic [CW-1:0]     y_q;
    logic [15:0]       paint_x_q;
    logic [15:0]       paint_y_q;
    logic [IF_W-1:0]   inflight_q;
    logic [IF_W-1:0]   inflight_d;
    pix_tag_t          tag_q [TAG_N];

    logic              issue;
    logic              last_coord;
    logic              fifo_wr;
    logic              fifo_rd;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [SUM_W-1:0]  credit_sum;
    pix_entry_t        wr_entry;
    pix_entry_t        rd_entry;

    // Tag stage LATENCY lines up with the colour for the coordinate issued LATENCY cycles ago.
    always_comb begin
        fifo_wr        = tag_q[LATENCY].valid;
        fifo_rd        = !fifo_empty && pix_ready;
        wr_entry.sof   = tag_q[LATENCY].sof;
        wr_entry.eol   = tag_q[LATENCY].eol;
        wr_entry.color = paint_color;
        credit_sum     = SUM_W'(fifo_count) + SUM_W'(inflight_q);
        issue          = (state_q == ST_SCAN) && (credit_sum < SUM_W'(FIFO_DEPTH));
        last_coord     = (x_q == X_LAST) && (y_q == Y_LAST);
        inflight_d     = inflight_q + IF_W'(issue) - IF_W'(fifo_wr);
        frame_done     = (state_q == ST_DRAIN) && (inflight_q == '0)
                         && (fifo_count == CNT_W'(1)) && fifo_rd;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            paint_x_q  <= '0;
            paint_y_q  <= '0;
            inflight_q <= '0;
            for (int i = 0; i < TAG_N; i++) tag_q[i] <= '0;
        end else begin
            inflight_q <= inflight_d;
            tag_q[0]   <= '0;
            for (int i = 1; i < TAG_N; i++) tag_q[i] <= tag_q[i-1];

            if (issue) begin
                tag_q[0]  <= '{valid: 1'b1, sof: (x_q == '0) && (y_q == '0), eol: (x_q == X_LAST)};
                paint_x_q <= {1'b0, x_q};
                paint_y_q <= {1'b0, y_q};
                if (x_q == X_LAST) begin
                    x_q <= '0;
                    y_q <= (y_q == Y_LAST) ? '0 : y_q + CW'(1);
                end else begin
                    x_q <= x_q + CW'(1);
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_q <= ST_SCAN;
                        busy_q  <= 1'b1;
                        x_q     <= '0;
                        y_q     <= '0;
                    end
                end
                ST_SCAN: begin
                    if (issue && last_coord) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (frame_done) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    paint_scan_streamer_pix_fifo #(
        .WIDTH ($bits(pix_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_pix_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_i    (fifo_wr),
        .wdata_i (wr_entry),
        .rd_i    (fifo_rd),
        .rdata_o (rd_entry),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign busy      = busy_q;
    assign paint_x   = paint_x_q;
    assign paint_y   = paint_y_q;
    assign pix_valid = !fifo_empty;
    assign pix_data  = rd_entry.color;
    assign pix_sof   = rd_entry.sof;
    assign pix_eol   = rd_entry.eol;

endmodule

// File: tb/tb_paint_scan_streamer.sv
// Directed bench for paint_scan_streamer on a reduced 8x4 frame with a stub paint pipeline
// returning {x[7:0],y[7:0]} LATENCY cycles after the coordinate.
module tb_paint_scan_streamer;

    localparam int XS  = 8;
    localparam int YS  = 4;
    localparam int LAT = 5;
    localparam int DEP = 16;
    localparam int NPX = XS * YS;

    logic        clk = 1'b0;
    logic        rstn;
    logic        frame_start;
    logic        busy;
    logic        frame_done;
    logic [15:0] paint_x;
    logic [15:0] paint_y;
    logic [15:0] paint_color;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sof;
    logic        pix_eol;

    logic [15:0] pipe_q [LAT];

    int n_chk  = 0;
    int n_pass = 0;
    int exp_x, exp_y;
    int rx_cnt = 0, done_cnt = 0, sof_cnt = 0, eol_cnt = 0;
    bit hold_pend = 1'b0;
    logic [17:0] hold_val;

    always #5 clk = ~clk;

    paint_scan_streamer #(
        .X_SIZE     (XS),
        .Y_SIZE     (YS),
        .LATENCY    (LAT),
        .FIFO_DEPTH (DEP)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .frame_start (frame_start),
        .busy        (busy),
        .frame_done  (frame_done),
        .paint_x     (paint_x),
        .paint_y     (paint_y),
        .paint_color (paint_color),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_sof     (pix_sof),
        .pix_eol     (pix_eol)
    );

    // Stub paint pipeline
    always @(posedge clk) begin
        pipe_q[0] <= {paint_x[7:0], paint_y[7:0]};
        for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign paint_color = pipe_q[LAT-1];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Scoreboard: every transfer must be the next raster pixel of the current frame
    always @(negedge clk) begin
        if (!rstn) begin
            exp_x     = 0;
            exp_y     = 0;
            hold_pend = 1'b0;
        end else begin
            if (hold_pend && pix_valid)
                check_eq("hold", {pix_sof, pix_eol, pix_data}, hold_val);
            hold_pend = pix_valid && !pix_ready;
            hold_val  = {pix_sof, pix_eol, pix_data};
            if (frame_done) done_cnt++;
            if (pix_valid && pix_ready) begin
                check_eq("pix_data", pix_data, {exp_x[7:0], exp_y[7:0]});
                check_eq("pix_sof", pix_sof, (exp_x == 0 && exp_y == 0));
                check_eq("pix_eol", pix_eol, (exp_x == XS - 1));
                check_eq("frame_done", frame_done, (exp_x == XS - 1 && exp_y == YS - 1));
                rx_cnt++;
                if (pix_sof) sof_cnt++;
                if (pix_eol) eol_cnt++;
                if (exp_x == XS - 1) begin
                    exp_x = 0;
                    exp_y = (exp_y == YS - 1) ? 0 : exp_y + 1;
                end else begin
                    exp_x++;
                end
            end else if (frame_done) begin
                check_eq("frame_done_idle", frame_done, 1'b0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_frame(input int budget, input bit rnd, output int cyc);
        int d0;
        d0  = done_cnt;
        cyc = 0;
        while (done_cnt == d0 && cyc < budget) begin
            tick();
            cyc++;
            if (rnd) pix_ready = 1'($urandom_range(0, 1));
        end
        check_eq("frame_timeout", (done_cnt != d0), 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_frame_done"}, frame_done, 1'b0);
        check_eq({tag, "_paint_x"}, paint_x, 16'd0);
        check_eq({tag, "_paint_y"}, paint_y, 16'd0);
        check_eq({tag, "_pix_valid"}, pix_valid, 1'b0);
        check_eq({tag, "_pix_data"}, pix_data, 16'd0);
        check_eq({tag, "_pix_sof"}, pix_sof, 1'b0);
        check_eq({tag, "_pix_eol"}, pix_eol, 1'b0);
    endtask

    initial begin
        int cyc, rx0, d0, s0, e0;
        rstn        = 1'b0;
        frame_start = 1'b0;
        pix_ready   = 1'b0;
        repeat (3) tick();
        check_reset_outputs("rst");
        rstn = 1'b1;
        tick();

        // Full-rate frame: raster order, markers, latency
        pix_ready = 1'b1;
        rx0 = rx_cnt; d0 = done_cnt; s0 = sof_cnt; e0 = eol_cnt;
        start_frame();
        check_eq("t1_busy", busy, 1'b1);
        wait_frame(500, 1'b0, cyc);
        check_eq("t1_cycles", cyc, NPX + LAT + 2);
        check_eq("t1_rx", rx_cnt - rx0, NPX);
        check_eq("t1_sof", sof_cnt - s0, 1);
        check_eq("t1_eol", eol_cnt - e0, YS);
        check_eq("t1_done", done_cnt - d0, 1);
        tick();
        check_eq("t1_idle", busy, 1'b0);

        // Stalled sink: exactly DEP coordinates issued, then freeze
        pix_ready = 1'b0;
        rx0 = rx_cnt;
        start_frame();
        repeat (30) tick();
        check_eq("t2_px", paint_x, 16'((DEP - 1) % XS));
        check_eq("t2_py", paint_y, 16'((DEP - 1) / XS));
        check_eq("t2_valid", pix_valid, 1'b1);
        check_eq("t2_sof", pix_sof, 1'b1);
        repeat (5) tick();
        check_eq("t2_px_frozen", paint_x, 16'((DEP - 1) % XS));
        check_eq("t2_rx_none", rx_cnt - rx0, 0);
        pix_ready = 1'b1;
        wait_frame(500, 1'b0, cyc);
        check_eq("t2_rx", rx_cnt - rx0, NPX);

        // Random back-pressure over several frames
        rx0 = rx_cnt; d0 = done_cnt;
        for (int f = 0; f < 3; f++) begin
            start_frame();
            wait_frame(1000, 1'b1, cyc);
            pix_ready = 1'b1;
            tick();
        end
        check_eq("t3_rx", rx_cnt - rx0, 3 * NPX);
        check_eq("t3_done", done_cnt - d0, 3);

        // frame_start during SCAN and DRAIN is ignored
        pix_ready = 1'b1;
        rx0 = rx_cnt; d0 = done_cnt;
        start_frame();
        repeat (4) tick();
        start_frame();
        check_eq("t4_busy_scan", busy, 1'b1);
        repeat (28) tick();
        start_frame();
        check_eq("t4_busy_drain", busy, 1'b1);
        wait_frame(500, 1'b0, cyc);
        repeat (12) tick();
        check_eq("t4_idle", busy, 1'b0);
        check_eq("t4_done", done_cnt - d0, 1);
        check_eq("t4_rx", rx_cnt - rx0, NPX);
        rx0 = rx_cnt;
        start_frame();
        wait_frame(500, 1'b0, cyc);
        check_eq("t4_rx2", rx_cnt - rx0, NPX);

        // Reset mid-frame, then a clean frame
        rx0 = rx_cnt;
        start_frame();
        cyc = 0;
        while (rx_cnt - rx0 < 20 && cyc < 200) begin
            tick();
            cyc++;
        end
        check_eq("t5_reach", (rx_cnt - rx0 >= 20), 1'b1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check_reset_outputs("t5");
        repeat (8) tick();
        check_eq("t5_quiet_valid", pix_valid, 1'b0);
        rx0 = rx_cnt; d0 = done_cnt; s0 = sof_cnt;
        start_frame();
        wait_frame(500, 1'b0, cyc);
        check_eq("t5_cycles", cyc, NPX + LAT + 2);
        check_eq("t5_rx", rx_cnt - rx0, NPX);
        check_eq("t5_sof", sof_cnt - s0, 1);
        check_eq("t5_done", done_cnt - d0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
